// File: rtl/reg_dump.sv
// Read-side register-file dump sequencer: walks a wrapping address range through one
// combinational read port and streams each byte out over a valid/ready handshake.
module reg_dump #(
  parameter int unsigned pw = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [pw-1:0] first_addr,
  input  logic [pw:0]   count,
  output logic [pw:0]   rd_addr,
  input  logic [7:0]    rd_data,
  output logic [7:0]    dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  localparam logic [pw:0] OneCnt = (pw + 1)'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [pw-1:0] ptr_q, ptr_d;
  logic [pw:0]   remaining_q, remaining_d;
  logic [7:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          load;
  logic          handshake;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      dout_q      <= 8'h00;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    handshake   = valid_q && dout_ready;
    // A new read may fill the output register when it is empty or being drained.
    load        = (state_q == StRun) && (remaining_q != '0) && (!valid_q || dout_ready);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StRun;
          ptr_d       = first_addr;
          remaining_d = count;
        end
      end
      StRun: begin
        if (load) begin
          dout_d      = rd_data;
          valid_d     = 1'b1;
          last_d      = (remaining_q == OneCnt);
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end else if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        if ((remaining_q == '0) && (!valid_q || dout_ready)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_addr    = {1'b0, ptr_q};
    busy       = (state_q == StRun);
    done       = done_q;
    dout       = dout_q;
    dout_valid = valid_q;
    dout_last  = last_q;
  end

endmodule

// File: tb/tb_reg_dump.sv
// Randomised self-checking bench for reg_dump: expected beats come from a queue built
// from the register contents and the wrapping address range of each dump.
module tb_reg_dump;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] first_addr;
  logic [4:0] count;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Register file: reg[i] = 8'h10 + i, except register 0 which reads as zero.
  assign rd_data = (rd_addr[3:0] == 4'd0) ? 8'h00 : 8'h10 + {4'h0, rd_addr[3:0]};

  reg_dump #(.pw(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_addr(first_addr),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [7:0] reg_val(input int a);
    int i;
    i = a % Depth;
    return (i == 0) ? 8'h00 : 8'(8'h10 + i);
  endfunction

  // Runs one dump from the current negedge. mode: 0 ready high, 1 random ready,
  // 2 ready low for 3 cycles from the first valid beat. ignore_at: cycle of a stray start.
  task automatic do_dump(input string name, input int first, input int cnt, input int mode,
                         input int ignore_at);
    logic [7:0] expq[$];
    logic [7:0] prev_dout;
    logic       prev_last;
    logic [4:0] prev_addr;
    logic       exp_last;
    bit         got_done;
    bit         prev_stall;
    int         idx;
    int         t;
    int         stall_left;

    for (int k = 0; k < cnt; k++) expq.push_back(reg_val(first + k));

    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_busy: got %b want 0", name, busy);
    end
    start      = 1'b1;
    first_addr = 4'(first);
    count      = 5'(cnt);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    n_tests++;
    if (rd_addr !== 5'(first)) begin
      n_fail++;
      $display("FAIL %s rd_addr_after_start: got %0h want %0h", name, rd_addr, first);
    end
    n_tests++;
    if (done !== 1'b0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_valid_after_start: got %b%b want 00", name, done, dout_valid);
    end

    idx        = 0;
    t          = 0;
    got_done   = 0;
    prev_stall = 0;
    stall_left = -1;
    prev_dout  = '0;
    prev_last  = 1'b0;
    prev_addr  = '0;
    while (!got_done && t < 200) begin
      if (prev_stall) begin
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== prev_dout || dout_last !== prev_last ||
            rd_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL %s stall_hold: got v=%b d=%0h l=%b a=%0h want v=1 d=%0h l=%b a=%0h",
                   name, dout_valid, dout, dout_last, rd_addr, prev_dout, prev_last, prev_addr);
        end
      end
      if (done === 1'b1) begin
        got_done = 1;
      end else begin
        if (ignore_at == t) begin
          start      = 1'b1;
          first_addr = 4'd9;
          count      = 5'd7;
        end else begin
          start = 1'b0;
        end
        case (mode)
          0: dout_ready = 1'b1;
          1: dout_ready = 1'($urandom_range(0, 1));
          default: begin
            if (dout_valid === 1'b1 && stall_left < 0) stall_left = 3;
            if (stall_left > 0) begin
              dout_ready = 1'b0;
              stall_left--;
            end else begin
              dout_ready = 1'b1;
            end
          end
        endcase
        if (dout_valid === 1'b1) begin
          n_tests++;
          if (idx >= cnt) begin
            n_fail++;
            $display("FAIL %s extra_beat: got beat %0h after %0d beats want none", name, dout,
                     idx);
          end else if (dout_ready) begin
            exp_last = (idx == cnt - 1);
            if (dout !== expq[idx] || dout_last !== exp_last) begin
              n_fail++;
              $display("FAIL %s beat%0d: got d=%0h l=%b want d=%0h l=%b", name, idx, dout,
                       dout_last, expq[idx], exp_last);
            end
            idx++;
          end
        end
        prev_stall = (dout_valid === 1'b1) && !dout_ready;
        prev_dout  = dout;
        prev_last  = dout_last;
        prev_addr  = rd_addr;
        @(posedge clk);
        @(negedge clk);
        t++;
      end
    end
    start = 1'b0;

    n_tests++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL %s timeout: got no done in %0d cycles want done", name, t);
    end else begin
      n_tests++;
      if (idx != cnt) begin
        n_fail++;
        $display("FAIL %s beat_count: got %0d want %0d", name, idx, cnt);
      end
      if (mode == 0) begin
        n_tests++;
        if (t != cnt + 1) begin
          n_fail++;
          $display("FAIL %s done_cycle: got E+%0d want E+%0d", name, t, cnt + 1);
        end
      end
      n_tests++;
      if (busy !== 1'b0 || dout_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s end_state: got busy=%b valid=%b want 0 0", name, busy, dout_valid);
      end
      n_tests++;
      if (rd_addr !== 5'((first + cnt) % Depth)) begin
        n_fail++;
        $display("FAIL %s end_ptr: got %0h want %0h", name, rd_addr, (first + cnt) % Depth);
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b0;
    first_addr = '0;
    count      = '0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || rd_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_values: got d=%0h v=%b l=%b b=%b dn=%b a=%0h want all zero", dout,
               dout_valid, dout_last, busy, done, rd_addr);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_dump("basic", 2, 4, 0, -1);
  endtask

  task automatic test_wrap();
    do_dump("wrap", 14, 4, 0, -1);
  endtask

  task automatic test_backpressure();
    do_dump("backpressure", 1, 3, 2, -1);
  endtask

  task automatic test_count_zero();
    do_dump("count_zero", 7, 0, 0, -1);
  endtask

  task automatic test_full();
    do_dump("full", 0, 16, 0, -1);
  endtask

  task automatic test_ignored_start();
    do_dump("ignored_start", 4, 6, 0, 3);
  endtask

  task automatic test_reset_mid_dump();
    dout_ready = 1'b1;
    start      = 1'b1;
    first_addr = 4'd5;
    count      = 5'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    // Beats are accepted on edges E+2 and E+3.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (dout_valid !== 1'b0 || dout_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        rd_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dump: got v=%b l=%b b=%b dn=%b a=%0h want 0 0 0 0 0",
               dout_valid, dout_last, busy, done, rd_addr);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: got dn=%b b=%b want 0 0", done, busy);
    end
    do_dump("after_reset", 3, 5, 0, -1);
  endtask

  task automatic test_back_to_back();
    do_dump("b2b_first", 10, 2, 0, -1);
    do_dump("b2b_second", 12, 3, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_dump("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_full();
    test_ignored_start();
    test_reset_mid_dump();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
